// File: rtl/pio_reg_pkg.sv
// Shared widths and master FSM state encoding for the PIO register bus.
package pio_reg_pkg;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } pio_mst_state_e;

endpackage

// File: rtl/pio_bus_master.sv
// PIO bus master: turns one upstream request into a SETUP/ACCESS cycle on the
// register slave, waits out busy with a timeout, and returns a held response.
module pio_bus_master #(
    parameter int unsigned ADDR_WIDTH  = pio_reg_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = pio_reg_pkg::DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  sel,
    output logic                  RW,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  busy
);

    import pio_reg_pkg::*;

    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYC - 1);

    pio_mst_state_e        state_q, state_d;
    logic                  hold_rw_q, hold_rw_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;

    always_comb begin
        state_d      = state_q;
        hold_rw_d    = hold_rw_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    hold_rw_d    = req_rw;
                    hold_addr_d  = req_addr;
                    hold_wdata_d = req_wdata;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (busy) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // Completion wins over a timeout landing in the same cycle.
                if (!busy) begin
                    rdata_d = hold_rw_q ? '0 : rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CntLast) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_rw_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            hold_rw_q    <= hold_rw_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    // Gated by reset so nothing looks acceptable while reset is held low.
    assign req_ready = (state_q == IDLE) && reset;
    assign sel       = (state_q == SETUP) || (state_q == ACCESS);
    assign RW        = sel && hold_rw_q;
    assign addr      = hold_addr_q;
    assign wdata     = hold_wdata_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_pio_bus_master.sv
// Directed self-checking bench for pio_bus_master: write, wait-state read,
// timeout, response backpressure, reset mid-access and busy/timeout collision.
module tb_pio_bus_master;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sel;
    logic        RW;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int sel_n;

    pio_bus_master #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rw   (req_rw),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .sel      (sel),
        .RW       (RW),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request, then drives busy high for busy_n ACCESS cycles.
    // Returns at the negedge of the first cycle after sel drops.
    task automatic do_txn(input logic rw, input logic [15:0] a, input logic [31:0] wd,
                          input int busy_n, input logic [31:0] rd_drive, input string tag,
                          output int sel_cnt);
        int guard;
        @(negedge clk);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = wd;
        busy      = 1'b1;
        rdata     = rd_drive;
        @(negedge clk);
        // Junk on req_* must not reach the slave side.
        req_valid = 1'b0;
        req_rw    = ~rw;
        req_addr  = ~a;
        req_wdata = ~wd;
        sel_cnt   = 0;
        guard     = 0;
        while (sel && guard < 100) begin
            sel_cnt++;
            check_eq({tag, "_RW"}, 32'(RW), 32'(rw));
            check_eq({tag, "_addr"}, 32'(addr), 32'(a));
            check_eq({tag, "_wdata"}, wdata, wd);
            busy = (sel_cnt >= 2) ? ((sel_cnt - 2) < busy_n) : 1'b1;
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_sel_bound"}, 32'(guard < 100), 32'd1);
        busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        rdata     = '0;
        busy      = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_sel", 32'(sel), 32'd0);
        check_eq("rst_RW", 32'(RW), 32'd0);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_wdata", wdata, 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Zero-wait write; rdata is driven nonzero to show writes return 0.
        do_txn(1'b1, 16'h0004, 32'hA5A5_0001, 0, 32'hFFFF_FFFF, "wr", sel_n);
        check_eq("wr_sel_cycles", 32'(sel_n), 32'd2);
        check_eq("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("wr_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("wr_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("wr_RW_idle", 32'(RW), 32'd0);
        @(negedge clk);
        check_eq("wr_done_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("wr_done_req_ready", 32'(req_ready), 32'd1);

        do_txn(1'b0, 16'h0008, 32'h0, 3, 32'h1234_5678, "rd", sel_n);
        check_eq("rd_sel_cycles", 32'(sel_n), 32'd5);
        check_eq("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check_eq("rd_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);

        do_txn(1'b0, 16'h0010, 32'h0, 1000, 32'hDEAD_BEEF, "to", sel_n);
        check_eq("to_sel_cycles", 32'(sel_n), 32'd17);
        check_eq("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("to_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("to_rsp_err", 32'(rsp_err), 32'd1);
        @(negedge clk);

        // Busy falls exactly when the counter sits at TIMEOUT_CYC-1.
        do_txn(1'b0, 16'h0014, 32'h0, 15, 32'h0BAD_F00D, "sim", sel_n);
        check_eq("sim_sel_cycles", 32'(sel_n), 32'd17);
        check_eq("sim_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
        check_eq("sim_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);

        rsp_ready = 1'b0;
        do_txn(1'b0, 16'h000C, 32'h0, 1, 32'hCAFE_0001, "bp", sel_n);
        check_eq("bp_sel_cycles", 32'(sel_n), 32'd3);
        rdata = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
            check_eq("bp_rsp_err", 32'(rsp_err), 32'd0);
            check_eq("bp_req_ready", 32'(req_ready), 32'd0);
            check_eq("bp_sel", 32'(sel), 32'd0);
            req_valid = 1'b1;
            req_rw    = 1'b1;
            req_addr  = 16'h0020;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check_eq("bp_release_valid", 32'(rsp_valid), 32'd1);
        check_eq("bp_release_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq("bp_idle_sel", 32'(sel), 32'd0);
        check_eq("bp_idle_req_ready", 32'(req_ready), 32'd1);
        check_eq("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("bp_after_sel", 32'(sel), 32'd0);

        // Reset while the slave holds busy in ACCESS.
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 16'h0030;
        busy      = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("rstmid_setup_sel", 32'(sel), 32'd1);
        @(negedge clk);
        check_eq("rstmid_access_sel", 32'(sel), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rstmid_sel", 32'(sel), 32'd0);
        check_eq("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rstmid_state", 32'(dut.state_q), 32'(pio_reg_pkg::IDLE));
        check_eq("rstmid_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        busy  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
            check_eq("rstmid_no_sel", 32'(sel), 32'd0);
        end
        check_eq("rstmid_req_ready_back", 32'(req_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pio_bus_master.md
PIO_BUS_MASTER -- requirements
Module: pio_bus_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default pio_reg_pkg::ADDR_WIDTH, the PIO address width.
REQ-002 SHALL have parameter DATA_WIDTH, default pio_reg_pkg::DATA_WIDTH, the PIO data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16, the maximum ACCESS cycles before abort (legal range 1..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_rw (in, 1; 1=write, 0=read), req_addr (in, ADDR_WIDTH) and req_wdata (in, DATA_WIDTH) forming the upstream request.
REQ-007 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_rdata (out, DATA_WIDTH) and rsp_err (out, 1; 1=timeout) forming the upstream response.
REQ-008 SHALL have ports sel (out, 1), RW (out, 1; 1=write), addr (out, ADDR_WIDTH) and wdata (out, DATA_WIDTH) driving the PIO register slave.
REQ-009 SHALL have ports rdata (in, DATA_WIDTH) and busy (in, 1) returned by the PIO register slave.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP.
REQ-011 SHALL drive req_ready=1 only in IDLE; a request is accepted on any cycle with req_valid && req_ready.
REQ-012 SHALL capture req_rw, req_addr and req_wdata into holding registers on acceptance, then go IDLE->SETUP.
REQ-013 SHALL drive sel, RW, addr and wdata from the holding registers only.
REQ-014 SHALL drive addr and wdata stable from SETUP until ACCESS exits.
REQ-015 SHALL assert sel=1 in SETUP and ACCESS, and sel=0 in IDLE and RESP.
REQ-016 SHALL drive RW=0 whenever sel=0.
REQ-017 SHALL go SETUP->ACCESS unconditionally after one cycle, clearing the timeout counter to 0.
REQ-018 SHALL sample busy each ACCESS cycle; when busy=0, the transfer is complete and the FSM goes to RESP.
REQ-019 SHALL, on completion of a read, capture rdata into rsp_rdata; for a write, rsp_rdata SHALL be 0.
REQ-020 SHALL, on completion, set rsp_err=0.
REQ-021 SHALL increment an 8-bit timeout counter in each ACCESS cycle with busy=1.
REQ-022 SHALL, when busy=1 and the counter equals TIMEOUT_CYC-1, go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-023 SHALL give busy=0 priority over timeout when both occur in the same cycle.
REQ-024 SHALL assert rsp_valid only in RESP and hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1.
REQ-025 SHALL go RESP->IDLE in the cycle rsp_valid && rsp_ready.
REQ-026 SHALL NOT accept a new request in that same cycle, giving a throughput of at most one transaction per 4 cycles.
REQ-027 SHALL give minimum latency: request accepted at T0, sel=1 at T1, busy sampled low at T2, rsp_valid=1 at T3.
REQ-028 SHALL ignore the req_* inputs in every state except IDLE.

Reset
REQ-029 SHALL, while reset=0 at a clock edge, force state=IDLE, req_ready=0, sel=0, RW=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and counter=0.
REQ-030 SHALL make req_ready=1 on the first cycle after reset returns to 1.
REQ-031 SHALL, on reset mid-transaction (SETUP, ACCESS or RESP), abandon the transaction immediately with no response and return sel=0 in the cycle after reset.

Structure
REQ-032 SHALL take ADDR_WIDTH, DATA_WIDTH and a shared enum pio_mst_state_e {IDLE, SETUP, ACCESS, RESP} from pio_reg_pkg.
REQ-033 SHALL be implemented as a single module with no sub-modules; the timeout counter and FSM are inline.

Verification
REQ-034 SHALL cover a write: req rw=1, addr=0x4, wdata=0xA5A5_0001, with busy=0 -> sel high exactly 2 cycles with RW=1, addr=0x4, wdata=0xA5A5_0001, then rsp_valid at T3 with rsp_err=0 and rsp_rdata=0.
REQ-035 SHALL cover a read with wait states: read at addr=0x8, busy high 3 ACCESS cycles, then rdata=0x1234_5678 with busy=0 -> rsp_rdata=0x1234_5678, rsp_err=0, and sel held 5 cycles.
REQ-036 SHALL cover a timeout: TIMEOUT_CYC=16 with busy stuck at 1 -> sel high 17 cycles (1 SETUP + 16 ACCESS), then rsp_err=1 and rsp_rdata=0.
REQ-037 SHALL cover response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0, and no new sel pulse while a pending req_valid is held.
REQ-038 SHALL cover reset mid-ACCESS: reset=0 during busy=1 -> next cycle sel=0, rsp_valid=0, state IDLE, and no response after release.
REQ-039 SHALL cover a simultaneous event: busy falls in the same cycle the counter reaches TIMEOUT_CYC-1 -> rsp_err=0 with valid read data.
